// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered 8N1/8N2 UART transmitter (8E1/8E2 when UART_TX_PARITY_EN is defined)
// Ports: clk core clock; rst async active-high reset; data/data_valid/data_ready byte push handshake;
//        tx serial line (idle high); busy frame in progress or FIFO non-empty; fifo_count FIFO occupancy.
// tx is registered from the next-state decode, so the line changes on the same edge as the FSM.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 347,
  parameter int FIFO_AW = 4,
  parameter int STOP_BITS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] data,
  input  logic data_valid,
  output logic data_ready,
  output logic tx,
  output logic busy,
  output logic [FIFO_AW:0] fifo_count
);
  localparam int CW = CLKS_PER_BIT > 2 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(2**FIFO_AW);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT-1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par, par_n;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [7:0] mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] shift, shift_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic sb, sb_n, tx_n, push, pop, last;
  assign data_ready = fifo_count != DEPTH;
  assign push = data_valid & data_ready;
  assign busy = (state != IDLE) | (fifo_count != '0);
  assign last = cnt == LAST;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      shift <= '0;
      bit_idx <= '0;
      cnt <= '0;
      sb <= 1'b0;
      tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      wr_ptr <= wr_ptr + FIFO_AW'(push);
      rd_ptr <= rd_ptr + FIFO_AW'(pop);
      fifo_count <= fifo_count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      shift <= shift_n;
      bit_idx <= bit_idx_n;
      cnt <= cnt_n;
      sb <= sb_n;
      tx <= tx_n;
`ifdef UART_TX_PARITY_EN
      par <= par_n;
`endif
    end
  end
  always_comb begin
    state_n = state;
    shift_n = shift;
    bit_idx_n = bit_idx;
    sb_n = sb;
    pop = 1'b0;
    cnt_n = last ? '0 : cnt + 1'b1;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        pop = fifo_count != '0;
      end
      START: if (last) state_n = DATA;
      DATA: if (last) begin
        shift_n = shift >> 1;
        bit_idx_n = bit_idx + 1'b1;
        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
          sb_n = 1'b0;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (last) begin
        state_n = STOP;
        sb_n = 1'b0;
      end
`endif
      STOP: if (last && sb == 1'(STOP_BITS-1)) begin
        state_n = IDLE;
        pop = fifo_count != '0;
      end else if (last) sb_n = 1'b1;
      default: state_n = IDLE;
    endcase
    // A pop from IDLE or the end of STOP launches the next frame with no gap
    if (pop) begin
      state_n = START;
      shift_n = mem[rd_ptr];
      bit_idx_n = '0;
      cnt_n = '0;
    end
`ifdef UART_TX_PARITY_EN
    par_n = pop ? ^mem[rd_ptr] : par;
    tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? shift_n[0] : (state_n == PARITY) ? par_n : 1'b1;
`else
    tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? shift_n[0] : 1'b1;
`endif
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench; accepted bytes queue up, a line receiver decodes tx and compares
module tb_uart_tx_fifo;
  localparam int C = 4, AW = 2;
`ifdef UART_TX_PARITY_EN
  localparam int SB = 2, PB = 1;
`else
  localparam int SB = 1, PB = 0;
`endif
  localparam int NB = 9 + PB + SB, F = NB * C;
  logic clk = 0, rst, data_valid, data_ready, tx, busy;
  logic [7:0] data;
  logic [AW:0] fifo_count;
  int cyc = 0, n_chk = 0, n_fail = 0, n_frames = 0, last_acc = 0;
  int a, fall, n0, nf;
  bit saw_full;
  logic [7:0] exp_q[$];
  int starts[$];
  logic [NB-1:0] mb;
  logic [7:0] m_byte;
  bit m_ok, m_abort;
  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_AW(AW), .STOP_BITS(SB)) dut (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .tx(tx), .busy(busy), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic push(input logic [7:0] b);
    int t = 0;
    data = b;
    data_valid = 1;
    while (!data_ready && t < 2000) begin
      saw_full = 1;
      chk("full_count", fifo_count, 4);
      @(negedge clk);
      t++;
    end
    if (!data_ready) chk("push_timeout", 0, 1);
    else begin
      exp_q.push_back(b);
      last_acc = cyc + 1;
      @(negedge clk);
    end
    data_valid = 0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", busy, 0);
    fall = cyc;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        starts.push_back(cyc);
        m_ok = 1;
        m_abort = 0;
        for (int b = 0; b < NB && !m_abort; b++)
          for (int k = 0; k < C && !m_abort; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (rst) m_abort = 1;
            else if (k == 0) mb[b] = tx;
            else if (tx !== mb[b]) m_ok = 0;
          end
        if (!m_abort) begin
          m_byte = mb[8:1];
          chk("bit_stable", m_ok, 1);
          chk("stop_bits", mb[NB-1 -: SB], (1 << SB) - 1);
`ifdef UART_TX_PARITY_EN
          chk("parity", mb[9], ^m_byte);
`endif
          chk("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("rx_byte", m_byte, exp_q.pop_front());
          n_frames++;
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1;
    data = 0;
    data_valid = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", data_ready, 1);
    rst = 0;
    repeat (2) @(negedge clk);
    push(8'hA5);
    a = last_acc;
    chk("tx_pre_launch", tx, 1);
    wait_idle();
    chk("lat_start", starts[$], a + 1);
    chk("busy_fall", fall, a + 1 + F);
    n0 = starts.size();
    push(8'h00);
    push(8'hFF);
    wait_idle();
    chk("b2b_frames", starts.size() - n0, 2);
    if (starts.size() - n0 == 2) chk("b2b_gap", starts[n0+1] - starts[n0], F);
    saw_full = 0;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    wait_idle();
    chk("saw_full", saw_full, 1);
    push(8'h21);
    a = last_acc;
    push(8'h22);
    while (cyc < a + 40) @(negedge clk);
    chk("pp_before", fifo_count, 1);
    push(8'h23);
    chk("pp_acc_edge", last_acc, a + 41);
    chk("pp_after", fifo_count, 1);
    wait_idle();
    push(8'h3C);
    a = last_acc;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    while (cyc < a + 18) @(negedge clk);
    chk("rst_pre_count", fifo_count, 3);
    chk("rst_pre_busy", busy, 1);
    #1 rst = 1;
    #1;
    chk("arst_tx", tx, 1);
    chk("arst_count", fifo_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", data_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    nf = n_frames;
    push(8'h55);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("post_rst_frames", n_frames - nf, 1);
    chk("post_rst_q_empty", exp_q.size(), 0);
`ifdef UART_TX_PARITY_EN
    push(8'h07);
    a = last_acc;
    wait_idle();
    chk("par_frame_len", fall - starts[$], 48);
`endif
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(8'($urandom));
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("drain_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
